// File: rtl/tl_repeat_sequencer_pkg.sv
// Shared types and constants for the TileLink repeat sequencer.
package tl_repeat_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic       ERR_SIZE     = 1'b0;
  localparam logic       ERR_ALIGN    = 1'b1;
  localparam logic [3:0] SIZE_ILLEGAL = 4'hf;

  // Number of fragments needed to cover a 2^size burst with 2^frag_lg pieces.
  function automatic logic [15:0] frag_count(input logic [3:0] size, input int unsigned frag_lg);
    if (32'(size) > frag_lg) begin
      return 16'd1 << (32'(size) - frag_lg);
    end
    return 16'd1;
  endfunction

endpackage

// File: rtl/tl_repeat_sequencer.sv
// Splits one burst request into 2^FRAG_LG-byte fragments and drives the
// downstream repeater's hold control until the final fragment.
module tl_repeat_sequencer
  import tl_repeat_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned FRAG_LG = 3,
  parameter int unsigned SRC_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [SRC_W-1:0]  in_source,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [3:0]        out_size,
  output logic [SRC_W-1:0]  out_source,
  output logic              out_last,
  // "repeat" is a reserved word, so the repeater hold carries a suffix
  output logic              repeat_o,
  output logic              err_valid,
  output logic              err_code
);

  localparam int unsigned IDX_W = 15 - FRAG_LG;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [3:0]         size_q, size_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_valid_q, err_valid_d;
  logic               err_code_q, err_code_d;

  logic               req_illegal;
  logic               req_misaligned;
  logic [ADDR_W-1:0]  align_mask;
  logic [IDX_W-1:0]   last_idx;
  logic               frag_last;

  assign req_illegal    = (in_size == SIZE_ILLEGAL);
  assign align_mask     = ~({ADDR_W{1'b1}} << in_size);
  assign req_misaligned = |(in_addr & align_mask);
  assign last_idx       = IDX_W'(frag_count(size_q, FRAG_LG) - 16'd1);
  assign frag_last      = (idx_q == last_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      size_q      <= '0;
      src_q       <= '0;
      idx_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_SIZE;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      size_q      <= size_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    size_d      = size_q;
    src_d       = src_q;
    idx_d       = idx_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (req_illegal) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SIZE;
          end else if (req_misaligned) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ALIGN;
          end else begin
            base_d  = in_addr;
            size_d  = in_size;
            src_d   = in_source;
            idx_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (frag_last) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything downstream is decoded from registered state only.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == ISSUE);
    out_last   = out_valid & frag_last;
    repeat_o   = out_valid & ~frag_last;
    out_addr   = base_q + (ADDR_W'(idx_q) << FRAG_LG);
    out_size   = (32'(size_q) > FRAG_LG) ? 4'(FRAG_LG) : size_q;
    out_source = src_q;
    err_valid  = err_valid_q;
    err_code   = err_code_q;
  end

endmodule

// File: doc/tl_repeat_sequencer.md
# tl_repeat_sequencer

Sequencer that drives the request repeater in front of a TileLink slave port. It accepts one burst request, splits it into fragments of at most 2^FRAG_LG bytes and presents them one at a time downstream. While fragments remain, it holds the repeater's `repeat` control, so the repeater never sees an enqueue while full. Illegal size (4'hf) and misaligned requests are rejected with an error pulse and never reach the repeater.

## Interface

Parameters:
- ADDR_W, 32, address width
- FRAG_LG, 3, log2 of fragment size in bytes (1..6)
- SRC_W, 4, source-id width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream request valid
- in_ready  out  1  upstream request accepted
- in_size  in  4  log2 bytes of burst; 0..14 legal, 4'hf illegal
- in_addr  in  ADDR_W  burst base address
- in_source  in  SRC_W  source id
- out_valid  out  1  fragment valid
- out_ready  in  1  downstream accepts fragment
- out_addr  out  ADDR_W  fragment address
- out_size  out  4  fragment log2 bytes
- out_source  out  SRC_W  copied from request
- out_last  out  1  current fragment is final
- repeat  out  1  repeater hold: out_valid & ~out_last
- err_valid  out  1  one-cycle pulse on rejected request
- err_code  out  1  0 = illegal size, 1 = misaligned

## Operation

- States: IDLE, ISSUE.
- IDLE: in_ready = 1. On in_valid:
  - If in_size == 4'hf: error with err_code 0.
  - Else if in_addr[in_size-1:0] != 0: error with err_code 1.
  - Else: capture base, size and source; clear the fragment index; go to ISSUE.
- Error handling: err_valid pulses the next cycle, err_code is held until the next error, and the state stays IDLE.
- ISSUE: in_ready = 0 and out_valid = 1.
  - Fragment count N = 2^(size-FRAG_LG) if size > FRAG_LG, else 1.
  - out_size = min(size, FRAG_LG).
  - out_addr = base + (idx << FRAG_LG), computed in ADDR_W bits; wrap at 2^ADDR_W is silent.
  - out_last = (idx == N-1).
  - Fragment index width is 15-FRAG_LG bits.
- On an out_valid & out_ready handshake: if out_last, go to IDLE; otherwise idx += 1.
- out_* fields stay stable while out_valid & ~out_ready.
- repeat is high from the first fragment cycle through the handshake of fragment N-2. It is low on the last fragment and in IDLE.
- Reset: a synchronous reset at any point (including mid-burst) forces IDLE on the next edge and abandons the remaining fragments. No error is raised.
- Reset values: in_ready 1 (follows IDLE), out_valid 0, out_last 0, repeat 0, err_valid 0, err_code 0, out_addr/out_size/out_source 0.

## Timing

- Request accepted at edge k → first fragment visible (out_valid = 1) in cycle k+1. There is no combinational path from in_* to out_*.
- One fragment per cycle when out_ready is held high. An N-fragment burst occupies N+1 cycles including the accept cycle.
- After the last handshake at edge m, in_ready = 1 in cycle m+1. There are no back-to-back accepts within a burst.
- err_valid is registered: rejected at edge k → err_valid = 1 only in cycle k+1.
- All outputs are registered or decoded from registered state only.
- out_ready has no effect in IDLE.

## Structure

- Package `tl_repeat_sequencer_pkg` holds:
  - state enum (IDLE, ISSUE)
  - err_code constants (ERR_SIZE = 0, ERR_ALIGN = 1)
  - constant SIZE_ILLEGAL = 4'hf
  - function frag_count(size, frag_lg)
- No sub-module. Address/index arithmetic and the FSM fit in one module.

## Test plan

- FRAG_LG=3, size 2, addr 0x1004 → one fragment: out_addr 0x1004, out_size 2, out_last 1, repeat 0. in_ready returns the cycle after the handshake.
- Size 5, addr 0x2000, out_ready=1 → fragments 0x2000, 0x2008, 0x2010, 0x2018 on four consecutive cycles. out_size 3; out_last only on 0x2018; repeat high on the first three.
- Size 5 burst with out_ready low for 3 cycles at fragment 0x2008 → out_addr, out_last and repeat are stable across the stall. The burst completes with no skipped or duplicated fragment.
- Size 4'hf, addr 0x0 → in_ready=1 accept; err_valid=1 with err_code 0 for exactly one cycle; out_valid never asserted.
- Size 4, addr 0x3008 → err_valid pulse with err_code 1; no fragments. A following legal request (size 3, addr 0x3008) issues normally.
- Size 6 (8 fragments), reset asserted one cycle while fragment 0x10 is presented → next cycle out_valid 0, repeat 0, in_ready 1. A new size-4 request at 0x4000 starts at fragment 0 (0x4000).
